// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte stream in (valid/ready) plus the instruction-memory write port.
// The loader sits on the slave modport; whoever feeds the stream and owns the memory uses master.
interface imem_loader_if #(
  parameter int MEM_SPACE = 8,
  parameter int ISIZE     = 16
);
  logic                 start;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 wr_en;
  logic [MEM_SPACE-1:0] wr_addr;
  logic [ISIZE-1:0]     wr_data;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, overflow
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian byte stream in,
// data writes from address 0, zero fill of the remainder, then a one-cycle done pulse.
module imem_loader #(
  parameter int MEM_SPACE = 8,
  parameter int ISIZE     = 16
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.slave   bus
);
  localparam int          DEPTH   = 2 ** MEM_SPACE;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    FILL    = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state_r, state_s;
  logic [15:0]          len_r, len_s, cnt_r, cnt_s;
  logic [7:0]           hi_r, hi_s;
  logic [MEM_SPACE:0]   fill_r, fill_s;
  logic                 ovf_r, ovf_s;
  logic                 wr_en_r, wr_en_s;
  logic [MEM_SPACE-1:0] wr_addr_r, wr_addr_s;
  logic [ISIZE-1:0]     wr_data_r, wr_data_s;
  logic                 in_ready_r, in_ready_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 hs_s;
  logic [15:0]          len_new_s, cnt_inc_s;

  // Next-state and next-output decode; outputs are derived from the state being entered.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    fill_s    = fill_r;
    ovf_s     = ovf_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    hs_s      = bus.in_valid & in_ready_r;
    len_new_s = {len_r[15:8], bus.in_data};
    cnt_inc_s = cnt_r + 16'd1;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = LEN_HI;
          ovf_s   = 1'b0;
          cnt_s   = 16'd0;
          fill_s  = {(MEM_SPACE+1){1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      LEN_HI: begin
        if (hs_s) begin
          len_s   = {bus.in_data, len_r[7:0]};
          state_s = LEN_LO;
        end else begin
          state_s = LEN_HI;
        end
      end
      LEN_LO: begin
        if (hs_s) begin
          len_s = len_new_s;
          if (len_new_s == 16'd0) begin
            state_s = FILL;
            fill_s  = {(MEM_SPACE+1){1'b0}};
          end else begin
            state_s = DATA_HI;
          end
        end else begin
          state_s = LEN_LO;
        end
      end
      DATA_HI: begin
        if (hs_s) begin
          hi_s    = bus.in_data;
          state_s = DATA_LO;
        end else begin
          state_s = DATA_HI;
        end
      end
      DATA_LO: begin
        if (hs_s) begin
          // Words beyond the memory are still consumed so the stream stays in sync.
          if ({1'b0, cnt_r} < DEPTH_W) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cnt_r[MEM_SPACE-1:0];
            wr_data_s = {hi_r, bus.in_data};
          end else begin
            ovf_s = 1'b1;
          end
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == len_r) begin
            if ({1'b0, len_r} < DEPTH_W) begin
              state_s = FILL;
              fill_s  = len_r[MEM_SPACE:0];
            end else begin
              state_s = DONE;
            end
          end else begin
            state_s = DATA_HI;
          end
        end else begin
          state_s = DATA_LO;
        end
      end
      FILL: begin
        wr_en_s   = 1'b1;
        wr_addr_s = fill_r[MEM_SPACE-1:0];
        wr_data_s = {ISIZE{1'b0}};
        fill_s    = fill_r + {{MEM_SPACE{1'b0}}, 1'b1};
        if (fill_r[MEM_SPACE-1:0] == {MEM_SPACE{1'b1}}) begin
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    in_ready_s = (state_s == LEN_HI) || (state_s == LEN_LO) ||
                 (state_s == DATA_HI) || (state_s == DATA_LO);
    busy_s     = (state_s != IDLE);
    done_s     = (state_s == DONE);
  end

  // Loader state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      len_r      <= 16'd0;
      cnt_r      <= 16'd0;
      hi_r       <= 8'd0;
      fill_r     <= {(MEM_SPACE+1){1'b0}};
      ovf_r      <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {MEM_SPACE{1'b0}};
      wr_data_r  <= {ISIZE{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      cnt_r      <= cnt_s;
      hi_r       <= hi_s;
      fill_r     <= fill_s;
      ovf_r      <= ovf_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (MEM_SPACE=4): random images and stream gaps,
// checked against a reference image model of what memory must receive.
module tb_imem_loader;
  localparam int MS    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.MEM_SPACE(MS), .ISIZE(16)) bus ();
  imem_loader #(.MEM_SPACE(MS), .ISIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Monitor-owned log of memory writes and event counters.
  logic [19:0] wlog [0:4095];
  int wcount    = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int busy_cnt  = 0;
  int hs_cnt    = 0;
  int ready_bad = 0;
  // Task-owned: byte budget of the current load, and handshake count at its start.
  int exp_bytes = 1000;
  int hs_base   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en && wcount < 4096) wlog[wcount] <= {bus.wr_addr, bus.wr_data};
    if (bus.wr_en) wcount <= wcount + 1;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.in_ready && (hs_cnt - hs_base) >= exp_bytes) ready_bad <= ready_bad + 1;
    if (bus.in_ready && bus.in_valid) hs_cnt <= hs_cnt + 1;
  end

  task automatic run_load(input string name, input int n, input logic [15:0] w[$],
                          input int duty, input bit noise);
    logic [7:0]  bytes[$];
    logic [19:0] exp[$];
    int wbase, dbase, bbase, rbase, start_c, idx, guard, nwr, lat;
    bit hs;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    foreach (w[i]) begin
      bytes.push_back(w[i][15:8]);
      bytes.push_back(w[i][7:0]);
    end
    // Expected image: each address once, declared words first, zeros for the rest.
    for (int a = 0; a < DEPTH; a++) begin
      if (a < n) exp.push_back({4'(a), w[a]});
      else       exp.push_back({4'(a), 16'h0000});
    end
    exp_bytes = bytes.size();
    hs_base   = hs_cnt;
    wbase = wcount; dbase = done_cnt; bbase = busy_cnt; rbase = ready_bad;

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    start_c = cyc;
    tests++;
    if (bus.overflow !== 1'b0) begin
      fails++; $display("FAIL %s.ovf_clear: got %b expected 0", name, bus.overflow);
    end

    idx = 0; guard = 0;
    while (idx < bytes.size() && guard < 2000) begin
      bus.in_valid = (duty >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_data  = bytes[idx];
      if (noise) bus.start = 1'($urandom_range(0, 1));
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    bus.start = 1'b0;
    tests++;
    if (idx != bytes.size()) begin
      fails++; $display("FAIL %s.stream_timeout: sent %0d bytes expected %0d", name, idx, bytes.size());
    end

    // Keep offering junk bytes; none may be accepted after the stream.
    guard = 0;
    while (!bus.done && guard < 300) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    bus.start = 1'b0;
    tests++;
    if (!bus.done) begin
      fails++; $display("FAIL %s.done_timeout: done not seen after %0d cycles", name, guard);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL %s.busy_after_done: got %b expected 0", name, bus.busy);
    end
    @(posedge clk); #1;

    nwr = wcount - wbase;
    tests++;
    if (nwr != DEPTH) begin
      fails++; $display("FAIL %s.write_count: got %0d expected %0d", name, nwr, DEPTH);
    end
    for (int i = 0; i < DEPTH && i < nwr; i++) begin
      tests++;
      if (wlog[wbase + i] !== exp[i]) begin
        fails++;
        $display("FAIL %s.write[%0d]: got addr %h data %h expected addr %h data %h", name, i,
                 wlog[wbase + i][19:16], wlog[wbase + i][15:0], exp[i][19:16], exp[i][15:0]);
      end
    end
    tests++;
    if (done_cnt - dbase != 1) begin
      fails++; $display("FAIL %s.done_pulses: got %0d expected 1", name, done_cnt - dbase);
    end
    tests++;
    if (bus.overflow !== (n > DEPTH)) begin
      fails++; $display("FAIL %s.overflow: got %b expected %b", name, bus.overflow, (n > DEPTH));
    end
    tests++;
    if (hs_cnt - hs_base != bytes.size()) begin
      fails++; $display("FAIL %s.accepted_bytes: got %0d expected %0d", name, hs_cnt - hs_base, bytes.size());
    end
    tests++;
    if (ready_bad != rbase) begin
      fails++; $display("FAIL %s.ready_after_stream: got %0d cycles expected 0", name, ready_bad - rbase);
    end
    tests++;
    if (busy_cnt - bbase != done_cyc - start_c + 1) begin
      fails++; $display("FAIL %s.busy_span: got %0d expected %0d", name, busy_cnt - bbase, done_cyc - start_c + 1);
    end
    if (duty >= 100) begin
      lat = 2 + 2 * n + ((n < DEPTH) ? (DEPTH - n) : 0) + 1;
      tests++;
      if (done_cyc - start_c + 1 != lat) begin
        fails++; $display("FAIL %s.latency: got %0d expected %0d", name, done_cyc - start_c + 1, lat);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.overflow} !== 5'b0 ||
        bus.wr_addr !== 4'h0 || bus.wr_data !== 16'h0000) begin
      fails++;
      $display("FAIL %s: got rdy=%b wen=%b busy=%b done=%b ovf=%b addr=%h data=%h expected all 0", name,
               bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.overflow, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload();
    logic [7:0]  pre[4];
    logic [15:0] w[$];
    int idx, guard;
    bit hs;
    pre = '{8'h00, 8'h05, 8'h12, 8'h34};
    exp_bytes = 1000;
    hs_base   = hs_cnt;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 4 && guard < 100) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pre[idx];
      hs = bus.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_midload");
    rst = 1'b1;
    @(posedge clk); #1;
    w.push_back(16'h00FF);
    run_load("reload_after_reset", 1, w, 100, 1'b0);
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    w.push_back(16'h1234); w.push_back(16'hABCD); w.push_back(16'h0001);
    run_load("basic", 3, w, 100, 1'b0);
    run_load("basic_gaps", 3, w, 50, 1'b0);
  endtask

  task automatic test_zero_len();
    logic [15:0] w[$];
    run_load("zero_len", 0, w, 100, 1'b0);
  endtask

  task automatic test_overflow();
    logic [15:0] w[$];
    for (int i = 0; i < 18; i++) w.push_back(16'($urandom));
    run_load("overflow", 18, w, 100, 1'b0);
    w = {};
    w.push_back(16'($urandom)); w.push_back(16'($urandom));
    run_load("after_overflow", 2, w, 100, 1'b0);
  endtask

  task automatic test_start_ignored();
    logic [15:0] w[$];
    for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
    run_load("start_ignored", 5, w, 100, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 20);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_load($sformatf("random%0d", k), n, w, ($urandom_range(0, 1) != 0) ? 100 : 50,
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_start_ignored();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
